// File: rtl/instr_queue_if.sv
// Fetch-to-decode instruction queue bus.
// Handshake: a fetch group of in_cnt slots is accepted on a rising edge where
// in_valid && in_ready; in_ready depends only on registered occupancy. Decode
// sees out_valid (thermometer) and consumes deq_cnt entries on the same edge,
// with no ready back-pressure; over-requests are clipped to what is valid.
interface instr_queue_if #(
  parameter int DECODE_NUM = 4,
  parameter int FETCH_NUM  = 4,
  parameter int DEPTH      = 16
);
  logic                              flush;
  logic                              in_valid;
  logic [$clog2(FETCH_NUM+1)-1:0]    in_cnt;
  logic [FETCH_NUM*32-1:0]           in_instr;
  logic [63:0]                       in_pc;
  logic                              in_ready;
  logic [DECODE_NUM-1:0]             out_valid;
  logic [DECODE_NUM*32-1:0]          out_instr;
  logic [DECODE_NUM*64-1:0]          out_pc;
  logic [$clog2(DECODE_NUM+1)-1:0]   deq_cnt;
  logic [$clog2(DEPTH):0]            count;

  // Fetch/decode side: drives requests, observes queue state.
  modport master (
    output flush, in_valid, in_cnt, in_instr, in_pc, deq_cnt,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, in_cnt, in_instr, in_pc, deq_cnt,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode. Accepts up to
// FETCH_NUM instructions per cycle and presents the oldest DECODE_NUM
// entries combinationally from the registered array. The storage array is
// not reset; only the pointers and occupancy are.
module instr_queue #(
  parameter int DECODE_NUM = 4,
  parameter int FETCH_NUM  = 4,
  parameter int DEPTH      = 16
) (
  input logic        clk,
  input logic        rst,
  instr_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_instr [DEPTH];
  logic [63:0]   mem_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic [CW-1:0] free_slots;
  logic          ready;
  logic [CW-1:0] in_cnt_c;
  logic          enq_fire;
  logic [CW-1:0] enq_cnt;
  logic [CW-1:0] deq_req;
  logic [CW-1:0] eff_deq;
  logic [CW-1:0] count_next;

  // Derive accept/consume amounts from registered state and this cycle's requests.
  always_comb begin
    free_slots = CW'(DEPTH) - count_q;
    ready      = free_slots >= CW'(FETCH_NUM);
    // An out-of-range in_cnt is clipped to the group width.
    in_cnt_c   = (CW'(bus.in_cnt) > CW'(FETCH_NUM)) ? CW'(FETCH_NUM) : CW'(bus.in_cnt);
    enq_fire   = bus.in_valid && ready && (in_cnt_c != '0);
    enq_cnt    = enq_fire ? in_cnt_c : '0;
    deq_req    = CW'(bus.deq_cnt);
    eff_deq    = deq_req;
    if (eff_deq > count_q)         eff_deq = count_q;
    if (eff_deq > CW'(DECODE_NUM)) eff_deq = CW'(DECODE_NUM);
    count_next = count_q + enq_cnt - eff_deq;
  end

  // Pointer and occupancy state; reset beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(eff_deq);
      wr_ptr  <= wr_ptr + PW'(enq_cnt);
      count_q <= count_next;
    end
  end

  // Storage writes: slot k of the fetch group lands at wr_ptr+k (wrapping).
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && enq_fire) begin
      for (int k = 0; k < FETCH_NUM; k++) begin
        if (CW'(k) < enq_cnt) begin
          mem_instr[wr_ptr + PW'(k)] <= bus.in_instr[32*k +: 32];
          mem_pc[wr_ptr + PW'(k)]    <= bus.in_pc + 64'(4 * k);
        end
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.count    = count_q;

  // Decode window: slot i reads entry rd_ptr+i; valid while i < occupancy.
  for (genvar i = 0; i < DECODE_NUM; i++) begin : g_out
    logic [PW-1:0] idx;
    assign idx                   = rd_ptr + PW'(i);
    assign bus.out_instr[32*i +: 32] = mem_instr[idx];
    assign bus.out_pc[64*i +: 64]    = mem_pc[idx];
    assign bus.out_valid[i]          = CW'(i) < count_q;
  end
endmodule

// File: tb/tb_instr_queue.sv
// Directed plus randomized bench for instr_queue, checked against a
// queue-based reference model of the fetch/decode buffer.
module tb_instr_queue;
  localparam int DN = 4;
  localparam int FN = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  instr_queue_if #(.DECODE_NUM(DN), .FETCH_NUM(FN), .DEPTH(DEPTH)) bus ();

  instr_queue #(.DECODE_NUM(DN), .FETCH_NUM(FN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: oldest entry at index 0.
  logic [31:0] exp_instr_q[$];
  logic [63:0] exp_pc_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Compare every observable output against the model.
  task automatic check_all(input string tag);
    int sz;
    logic [DN-1:0] ev;
    sz = exp_instr_q.size();
    ev = '0;
    for (int i = 0; i < DN; i++) if (i < sz) ev[i] = 1'b1;
    chk({tag, ".count"}, 64'(bus.count), 64'(sz));
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'((DEPTH - sz) >= FN));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
    for (int i = 0; i < DN && i < sz; i++) begin
      chk($sformatf("%s.instr%0d", tag, i), 64'(bus.out_instr[32*i +: 32]), 64'(exp_instr_q[i]));
      chk($sformatf("%s.pc%0d", tag, i), bus.out_pc[64*i +: 64], exp_pc_q[i]);
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input logic r, input logic f, input logic v, input int n,
                      input logic [63:0] pc, input int d);
    logic [FN*32-1:0] ins;
    int sz, eff;
    for (int k = 0; k < FN; k++) ins[32*k +: 32] = $urandom;
    rst          = r;
    bus.flush    = f;
    bus.in_valid = v;
    bus.in_cnt   = 3'(n);
    bus.in_instr = ins;
    bus.in_pc    = pc;
    bus.deq_cnt  = 3'(d);
    if (r || f) begin
      exp_instr_q.delete();
      exp_pc_q.delete();
    end else begin
      sz  = exp_instr_q.size();
      eff = d;
      if (eff > sz) eff = sz;
      if (eff > DN) eff = DN;
      for (int j = 0; j < eff; j++) begin
        void'(exp_instr_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (v && (DEPTH - sz) >= FN) begin
        for (int k = 0; k < n; k++) begin
          exp_instr_q.push_back(ins[32*k +: 32]);
          exp_pc_q.push_back(pc + 64'(4 * k));
        end
      end
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.deq_cnt  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_cnt = '0;
    bus.in_instr = '0; bus.in_pc = '0; bus.deq_cnt = '0;

    // Reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_all("reset");
    chk("reset.in_ready_c", 64'(bus.in_ready), 64'd1);

    // Basic enqueue of four
    step(0, 0, 1, 4, 64'h1000, 0);
    check_all("basic");
    chk("basic.pc3", bus.out_pc[64*3 +: 64], 64'h100C);
    chk("basic.pc0", bus.out_pc[63:0], 64'h1000);
    chk("basic.valid_c", 64'(bus.out_valid), 64'hF);

    // Fill to 16, then an ignored fifth group
    step(0, 0, 1, 4, 64'h1010, 0);
    step(0, 0, 1, 4, 64'h1020, 0);
    step(0, 0, 1, 4, 64'h1030, 0);
    check_all("full");
    chk("full.count_c", 64'(bus.count), 64'd16);
    chk("full.ready_c", 64'(bus.in_ready), 64'd0);
    step(0, 0, 1, 4, 64'h1040, 0);
    check_all("full5");
    chk("full5.count_c", 64'(bus.count), 64'd16);

    // Simultaneous: count 13, refused enqueue of 3 plus dequeue 2
    step(0, 0, 0, 0, 0, 3);
    chk("simul.count13", 64'(bus.count), 64'd13);
    chk("simul.ready13", 64'(bus.in_ready), 64'd0);
    step(0, 0, 1, 3, 64'h2000, 2);
    check_all("simul");
    chk("simul.count_c", 64'(bus.count), 64'd11);
    chk("simul.ready_c", 64'(bus.in_ready), 64'd1);

    // Partial / over-dequeue down to empty
    step(0, 0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 0, 1);
    check_all("partial");
    chk("partial.valid_c", 64'(bus.out_valid), 64'h3);
    step(0, 0, 0, 0, 0, 4);
    check_all("overdeq");
    chk("overdeq.valid_c", 64'(bus.out_valid), 64'h0);

    // Wrap: bring both pointers to 14, then enqueue four across the end
    step(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 1, 4, 64'h3000, 0);
      step(0, 0, 0, 0, 0, 4);
    end
    step(0, 0, 1, 2, 64'h3000, 0);
    step(0, 0, 0, 0, 0, 2);
    check_all("wrap_pre");
    step(0, 0, 1, 4, 64'h4000, 0);
    check_all("wrap");
    chk("wrap.pc3", bus.out_pc[64*3 +: 64], 64'h400C);
    step(0, 0, 0, 0, 0, 2);
    check_all("wrap_deq");

    // Flush with concurrent enqueue and dequeue
    step(0, 0, 1, 4, 64'h5000, 0);
    step(0, 0, 1, 3, 64'h5010, 0);
    chk("flush.count9", 64'(bus.count), 64'd9);
    step(0, 1, 1, 4, 64'h6000, 3);
    check_all("flush");
    chk("flush.count_c", 64'(bus.count), 64'd0);

    // Reset together with flush, from a full queue
    for (int j = 0; j < 4; j++) step(0, 0, 1, 4, 64'h7000 + 64'(16 * j), 0);
    check_all("rstfull_pre");
    step(1, 1, 1, 4, 64'h8000, 3);
    check_all("rstflush");
    chk("rstflush.ready_c", 64'(bus.in_ready), 64'd1);
    step(0, 0, 1, 2, 64'h9000, 0);
    check_all("post_rst");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic r, f, v;
      r = ($urandom_range(0, 79) == 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, f, v, $urandom_range(0, FN), {$urandom, $urandom} & ~64'h3,
           $urandom_range(0, 7));
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DECODE_NUM, default 4, max instructions presented to decode per cycle.
REQ-002 SHALL have parameter FETCH_NUM, default 4, max instructions accepted from fetch per cycle.
REQ-003 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2*max(FETCH_NUM, DECODE_NUM).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all entries (redirect/mispredict).
REQ-007 SHALL have port in_valid  input  1  fetch group present.
REQ-008 SHALL have port in_cnt  input  $clog2(FETCH_NUM+1)  valid instructions in group, slots 0..in_cnt-1.
REQ-009 SHALL have port in_instr  input  FETCH_NUM*32  instruction slots, slot k at bits [32k+31:32k].
REQ-010 SHALL have port in_pc  input  64  PC of slot 0; slot k PC = in_pc + 4k.
REQ-011 SHALL have port in_ready  output  1  queue can accept a full fetch group.
REQ-012 SHALL have port out_valid  output  DECODE_NUM  per-slot valid, thermometer-coded from bit 0.
REQ-013 SHALL have port out_instr  output  DECODE_NUM*32  oldest instructions, slot 0 oldest.
REQ-014 SHALL have port out_pc  output  DECODE_NUM*64  PC of each out_instr slot.
REQ-015 SHALL have port deq_cnt  input  $clog2(DECODE_NUM+1)  instructions consumed by decode this cycle.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL store per entry a 32-bit instruction and 64-bit PC in a circular array indexed by rd_ptr/wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-018 SHALL drive in_ready = (DEPTH - count) >= FETCH_NUM, from registered count only (no same-cycle dequeue credit).
REQ-019 SHALL enqueue when in_valid && in_ready: write slot k to entry wr_ptr+k, PC in_pc+4k, for k < in_cnt; wr_ptr += in_cnt.
REQ-020 SHALL treat in_valid with in_cnt==0, or in_valid while in_ready==0, as no-op (no write, no pointer change).
REQ-021 SHALL present out_instr/out_pc slot i = entry rd_ptr+i (mod DEPTH) combinationally; out_valid[i] = (i < count).
REQ-022 SHALL dequeue eff_deq = min(deq_cnt, count, DECODE_NUM) entries: rd_ptr += eff_deq.
REQ-023 SHALL update count_next = count + enq_cnt - eff_deq when enqueue and dequeue coincide; count never exceeds DEPTH.
REQ-024 SHALL, when flush=1, set rd_ptr, wr_ptr, count to 0 next cycle, ignoring same-cycle enqueue and dequeue.
REQ-025 SHALL treat out_instr/out_pc contents of slots with out_valid[i]==0 as don't-care.
REQ-026 SHALL be a registered-state design: enqueued data visible at out_* earliest the cycle after the enqueue edge (1-cycle latency).
REQ-027 SHALL not require storage array reset; only pointers and count are reset.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, set rd_ptr=0, wr_ptr=0, count=0; hence out_valid=0 and in_ready=1 the following cycle.
REQ-029 SHALL give rst priority over flush, enqueue and dequeue, including reset asserted mid-operation with a full queue.

Verification
REQ-030 Basic: reset, enqueue in_cnt=4 in_pc=0x1000, deq_cnt=0 -> next cycle count=4, out_valid=4'b1111, out_pc={0x100C,0x1008,0x1004,0x1000}.
REQ-031 Full: four enqueues of 4 with no dequeue -> count=16, in_ready=0; fifth in_valid ignored, count stays 16.
REQ-032 Simultaneous: count=13, enqueue 3 requested (in_ready=0 since 3 free < 4) while deq_cnt=2 -> count=11, then in_ready=1 next cycle.
REQ-033 Wrap: with rd_ptr=wr_ptr=14, enqueue 4 -> entries 14,15,0,1 written; out_instr order preserved, PCs consecutive across wrap.
REQ-034 Over-dequeue/partial: count=2, deq_cnt=4 -> count=0, rd_ptr+=2; out_valid=2'b11 pattern before, 0 after.
REQ-035 Flush vs reset: count=9 with flush=1 plus enqueue 4 and deq_cnt=3 -> count=0 next cycle; rst+flush together -> same result, rst priority checked.
